// File: rtl/fb_pixel_writer.sv
// Write-side front end of the RGB565 scaled frame buffer: turns (x, y, colour)
// pixel beats into linear BRAM writes and runs full-frame clear sweeps.
module fb_pixel_writer #(
  parameter int FRAME_WIDTH  = 320,
  parameter int FRAME_HEIGHT = 180,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  clear_in,
  input  logic [15:0]           clear_color_in,
  input  logic                  px_valid_in,
  output logic                  px_ready_out,
  input  logic [8:0]            px_x_in,
  input  logic [7:0]            px_y_in,
  input  logic [15:0]           px_data_in,
  input  logic                  px_last_in,
  output logic [ADDR_WIDTH-1:0] sbuf_w_addr_out,
  output logic                  sbuf_w_valid_out,
  output logic [15:0]           sbuf_w_data_out,
  output logic                  busy_out,
  output logic                  clear_done_out,
  output logic                  frame_done_out,
  output logic                  oob_out
);

  typedef enum logic [0:0] {IDLE, CLEAR} state_t;

  localparam logic [8:0]            X_LIMIT    = 9'(FRAME_WIDTH);
  localparam logic [7:0]            Y_LIMIT    = 8'(FRAME_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(FRAME_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(FRAME_WIDTH * FRAME_HEIGHT - 1);

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   clear_cnt;
  logic [15:0]             clear_color;
  logic [ADDR_WIDTH-1:0]   px_addr;
  logic                    handshake;
  logic                    clear_accept;
  logic                    px_in_bounds;
  logic                    clear_last;

  assign handshake    = px_valid_in && px_ready_out && (state == IDLE);
  assign clear_accept = clear_in && (state == IDLE);
  assign px_in_bounds = (px_x_in < X_LIMIT) && (px_y_in < Y_LIMIT);
  assign px_addr      = ADDR_WIDTH'(px_x_in) + ADDR_WIDTH'(px_y_in) * ROW_STRIDE;
  assign clear_last   = (clear_cnt == LAST_ADDR);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (clear_accept) next_state = CLEAR;
      CLEAR:   if (clear_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= next_state;
  end

  // Clear writes take priority; pixels can only retire while ready was high,
  // which never overlaps a cycle spent in CLEAR.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      px_ready_out     <= 1'b0;
      busy_out         <= 1'b0;
      sbuf_w_valid_out <= 1'b0;
      sbuf_w_addr_out  <= '0;
      sbuf_w_data_out  <= '0;
      clear_done_out   <= 1'b0;
      frame_done_out   <= 1'b0;
      oob_out          <= 1'b0;
      clear_cnt        <= '0;
      clear_color      <= '0;
    end else begin
      px_ready_out     <= (next_state == IDLE);
      busy_out         <= (next_state == CLEAR);
      sbuf_w_valid_out <= 1'b0;
      clear_done_out   <= 1'b0;
      frame_done_out   <= handshake && px_last_in;

      if (clear_accept) begin
        clear_color <= clear_color_in;
        clear_cnt   <= '0;
      end

      if (state == CLEAR) begin
        sbuf_w_valid_out <= 1'b1;
        sbuf_w_addr_out  <= clear_cnt;
        sbuf_w_data_out  <= clear_color;
        clear_done_out   <= clear_last;
        clear_cnt        <= clear_last ? '0 : clear_cnt + 1'b1;
      end else if (handshake && px_in_bounds) begin
        sbuf_w_valid_out <= 1'b1;
        sbuf_w_addr_out  <= px_addr;
        sbuf_w_data_out  <= px_data_in;
      end

      if (clear_accept)                    oob_out <= 1'b0;
      else if (handshake && !px_in_bounds) oob_out <= 1'b1;
    end
  end

endmodule
